// File: rtl/whack_scorer_pkg.sv
// whack_pkg: shared types and helpers for the whack-a-mole scorer.
//   state_t              game state machine encoding (IDLE, PLAY, OVER)
//   DEFAULT_NUM_HOLES    default hole / button / mole-bit count
//   DEFAULT_START_LIVES  default lives loaded when a game starts
//   sat_clamp()          clamps a signed running score into [0, max_val]
package whack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int DEFAULT_NUM_HOLES   = 18;
  localparam int DEFAULT_START_LIVES = 3;

  // Saturating finish for score + hits - misses: the caller does the add in a
  // widened signed word, and this function pins it to the legal score range.
  function automatic int sat_clamp(input int value, input int max_val);
    if (value < 0) begin
      return 0;
    end else if (value > max_val) begin
      return max_val;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/whack_scorer_if.sv
// whack_scorer_if: groups the game-facing signals of the scorer.
//   start           level, rising edge starts a game from IDLE or OVER
//   mole_positions  active mole bits from the mole generator
//   buttons         debounced player buttons, active high
//   visible_moles   moles still showing (whacked ones removed), zero unless PLAY
//   score / lives   current score and remaining lives
//   hit_pulse       one-cycle pulse when at least one hit registered
//   miss_pulse      one-cycle pulse when at least one miss registered
//   game_over       high while the game is in OVER
// master drives the game inputs (generator/player side); slave is the scorer.
interface whack_scorer_if
  import whack_pkg::*;
#(
  parameter int NUM_HOLES   = DEFAULT_NUM_HOLES,
  parameter int SCORE_WIDTH = 10,
  parameter int LIVES_WIDTH = 4
);

  logic                   start;
  logic [NUM_HOLES-1:0]   mole_positions;
  logic [NUM_HOLES-1:0]   buttons;
  logic [NUM_HOLES-1:0]   visible_moles;
  logic [SCORE_WIDTH-1:0] score;
  logic [LIVES_WIDTH-1:0] lives;
  logic                   hit_pulse;
  logic                   miss_pulse;
  logic                   game_over;

  modport master (
    output start, mole_positions, buttons,
    input  visible_moles, score, lives, hit_pulse, miss_pulse, game_over
  );

  modport slave (
    input  start, mole_positions, buttons,
    output visible_moles, score, lives, hit_pulse, miss_pulse, game_over
  );

endinterface

// File: rtl/whack_scorer_popcount.sv
// whack_scorer_popcount: combinational population count.
//   bits   input vector of WIDTH bits
//   count  number of set bits, $clog2(WIDTH+1) bits wide
module whack_scorer_popcount #(
  parameter int WIDTH = 18
) (
  input  logic [WIDTH-1:0]             bits,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  localparam int CW = $clog2(WIDTH + 1);

  // Simple ripple of one-bit adds; WIDTH is small so this stays shallow.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/whack_scorer.sv
// whack_scorer: turns mole positions and button presses into hits, misses,
// score, lives and game state, and masks whacked moles off the display.
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    whack_scorer_if.slave: start, mole_positions, buttons in;
//          visible_moles, score, lives, hit_pulse, miss_pulse, game_over out
module whack_scorer
  import whack_pkg::*;
#(
  parameter int NUM_HOLES   = DEFAULT_NUM_HOLES,
  parameter int SCORE_WIDTH = 10,
  parameter int START_LIVES = DEFAULT_START_LIVES,
  parameter int LIVES_WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  whack_scorer_if.slave  bus
);

  localparam int CW        = $clog2(NUM_HOLES + 1);
  localparam int SUMW      = SCORE_WIDTH + $clog2(NUM_HOLES) + 1;
  localparam int SCORE_MAX = (1 << SCORE_WIDTH) - 1;

  state_t                 state, state_next;
  logic [SCORE_WIDTH-1:0] score_r, score_next;
  logic [LIVES_WIDTH-1:0] lives_r, lives_next;
  logic [NUM_HOLES-1:0]   whacked, whacked_next;
  logic                   hit_r, hit_next;
  logic                   miss_r, miss_next;

  logic [NUM_HOLES-1:0]   prev_buttons, prev_moles;
  logic                   prev_start;

  logic [NUM_HOLES-1:0]   press, hits, misses, escaped;
  logic [CW-1:0]          hit_cnt, miss_cnt;
  logic signed [SUMW-1:0] score_sum;
  logic                   start_rise, wave_end;

  assign press      = bus.buttons & ~prev_buttons;
  assign start_rise = bus.start & ~prev_start;
  assign hits       = press & bus.mole_positions & ~whacked;
  assign misses     = press & ~bus.mole_positions;

  // A wave ends when the generator drops every mole; anything that was up
  // and never whacked (registered mask, so last cycle's hits count) escaped.
  assign wave_end = (prev_moles != '0) && (bus.mole_positions == '0);
  assign escaped  = prev_moles & ~whacked;

  whack_scorer_popcount #(.WIDTH(NUM_HOLES)) u_hit_count (
    .bits  (hits),
    .count (hit_cnt)
  );

  whack_scorer_popcount #(.WIDTH(NUM_HOLES)) u_miss_count (
    .bits  (misses),
    .count (miss_cnt)
  );

  // Widened word so that score - misses can go negative before clamping.
  assign score_sum = SUMW'(score_r) + SUMW'(hit_cnt) - SUMW'(miss_cnt);

  // Edge-detect history runs in every state so that a held button or start
  // level never looks like a fresh edge after a state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_buttons <= '0;
      prev_moles   <= '0;
      prev_start   <= 1'b0;
    end else begin
      prev_buttons <= bus.buttons;
      prev_moles   <= bus.mole_positions;
      prev_start   <= bus.start;
    end
  end

  // Game state register plus everything the next-state logic updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      score_r <= '0;
      lives_r <= '0;
      whacked <= '0;
      hit_r   <= 1'b0;
      miss_r  <= 1'b0;
    end else begin
      state   <= state_next;
      score_r <= score_next;
      lives_r <= lives_next;
      whacked <= whacked_next;
      hit_r   <= hit_next;
      miss_r  <= miss_next;
    end
  end

  // Next-state and scoring. Score update and life loss can land in the same
  // cycle; losing the last life moves to OVER but keeps the final score.
  always_comb begin
    state_next   = state;
    score_next   = score_r;
    lives_next   = lives_r;
    whacked_next = whacked;
    hit_next     = 1'b0;
    miss_next    = 1'b0;

    case (state)
      IDLE, OVER: begin
        if (start_rise) begin
          state_next   = PLAY;
          lives_next   = LIVES_WIDTH'(START_LIVES);
          score_next   = '0;
          whacked_next = '0;
        end
      end

      PLAY: begin
        whacked_next = (whacked | hits) & bus.mole_positions;
        score_next   = SCORE_WIDTH'(sat_clamp(int'(score_sum), SCORE_MAX));
        hit_next     = |hits;
        miss_next    = |misses;
        if (wave_end && (escaped != '0) && (lives_r != '0)) begin
          lives_next = lives_r - LIVES_WIDTH'(1);
          if (lives_r == LIVES_WIDTH'(1)) begin
            state_next = OVER;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.visible_moles = (state == PLAY) ? (bus.mole_positions & ~whacked) : '0;
  assign bus.score         = score_r;
  assign bus.lives         = lives_r;
  assign bus.hit_pulse     = hit_r;
  assign bus.miss_pulse    = miss_r;
  assign bus.game_over     = (state == OVER);

endmodule

// File: tb/tb_whack_scorer.sv
// tb_whack_scorer: self-checking bench for whack_scorer.
// Each row drives one cycle of inputs and pushes the outputs expected after
// the next clock edge; the row's task pops and compares them #1 after it.
module tb_whack_scorer;
  import whack_pkg::*;

  localparam int NH      = 18;
  localparam int SW      = 10;
  localparam int LW      = 4;
  localparam int ALL     = 'h3FFFF;
  localparam int SMAX    = 1023;
  localparam int OBS_W   = NH + SW + LW + 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  whack_scorer_if #(.NUM_HOLES(NH), .SCORE_WIDTH(SW), .LIVES_WIDTH(LW)) bus ();

  whack_scorer #(
    .NUM_HOLES   (NH),
    .SCORE_WIDTH (SW),
    .START_LIVES (3),
    .LIVES_WIDTH (LW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string         tag;
    logic          rst;
    logic          st;
    logic [NH-1:0] moles;
    logic [NH-1:0] btn;
    logic [NH-1:0] vis;
    logic [SW-1:0] score;
    logic [LW-1:0] lives;
    logic          hit;
    logic          miss;
    logic          over;
  } row_t;

  typedef logic [OBS_W-1:0] obs_t;

  obs_t  sb[$];
  string tag_q[$];
  int    n_compared   = 0;
  int    n_mismatched = 0;

  function automatic row_t mk(input string tag, input int rst, input int st,
                              input int moles, input int btn, input int vis,
                              input int score, input int lives, input int hit,
                              input int miss, input int over);
    row_t r;
    r.tag   = tag;
    r.rst   = (rst != 0);
    r.st    = (st != 0);
    r.moles = NH'(moles);
    r.btn   = NH'(btn);
    r.vis   = NH'(vis);
    r.score = SW'(score);
    r.lives = LW'(lives);
    r.hit   = (hit != 0);
    r.miss  = (miss != 0);
    r.over  = (over != 0);
    return r;
  endfunction

  // Drive one row's inputs and queue the outputs expected after the edge.
  task automatic applyStimulus(input row_t r);
    reset              = r.rst;
    bus.start          = r.st;
    bus.mole_positions = r.moles;
    bus.buttons        = r.btn;
    sb.push_back({r.vis, r.score, r.lives, r.hit, r.miss, r.over});
    tag_q.push_back(r.tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    rows.push_back(mk("reset_hold",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk("reset_hold2",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk("idle_masked",  0, 0, 5, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk("idle_press",   0, 0, 5, 4, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk("idle_release", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (rows[i]) begin
      obs_t exp, act;
      string tag;
      applyStimulus(rows[i]);
      step();
      exp = sb.pop_front();
      tag = tag_q.pop_front();
      act = {bus.visible_moles, bus.score, bus.lives, bus.hit_pulse, bus.miss_pulse, bus.game_over};
      n_compared++;
      if (act !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL reset/%s: got vis=%h score=%0d lives=%0d hit/miss/over=%b%b%b, want vis=%h score=%0d lives=%0d hit/miss/over=%b%b%b",
                 tag, act[OBS_W-1 -: NH], act[SW+LW+2 -: SW], act[LW+2 -: LW], act[2], act[1], act[0],
                 exp[OBS_W-1 -: NH], exp[SW+LW+2 -: SW], exp[LW+2 -: LW], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_start();
    row_t rows[$];
    rows.push_back(mk("start_rise", 0, 1, 0, 0, 0, 0, 3, 0, 0, 0));
    rows.push_back(mk("start_held", 0, 1, 0, 0, 0, 0, 3, 0, 0, 0));
    rows.push_back(mk("start_low",  0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    foreach (rows[i]) begin
      obs_t exp, act;
      string tag;
      applyStimulus(rows[i]);
      step();
      exp = sb.pop_front();
      tag = tag_q.pop_front();
      act = {bus.visible_moles, bus.score, bus.lives, bus.hit_pulse, bus.miss_pulse, bus.game_over};
      n_compared++;
      if (act !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL start/%s: got vis=%h score=%0d lives=%0d hit/miss/over=%b%b%b, want vis=%h score=%0d lives=%0d hit/miss/over=%b%b%b",
                 tag, act[OBS_W-1 -: NH], act[SW+LW+2 -: SW], act[LW+2 -: LW], act[2], act[1], act[0],
                 exp[OBS_W-1 -: NH], exp[SW+LW+2 -: SW], exp[LW+2 -: LW], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_hit();
    row_t rows[$];
    rows.push_back(mk("wave_up",  0, 0, 5, 0, 5, 0, 3, 0, 0, 0));
    rows.push_back(mk("hit_h2",   0, 0, 5, 4, 1, 1, 3, 1, 0, 0));
    rows.push_back(mk("release",  0, 0, 5, 0, 1, 1, 3, 0, 0, 0));
    rows.push_back(mk("rehit_h2", 0, 0, 5, 4, 1, 1, 3, 0, 0, 0));
    rows.push_back(mk("release2", 0, 0, 5, 0, 1, 1, 3, 0, 0, 0));
    foreach (rows[i]) begin
      obs_t exp, act;
      string tag;
      applyStimulus(rows[i]);
      step();
      exp = sb.pop_front();
      tag = tag_q.pop_front();
      act = {bus.visible_moles, bus.score, bus.lives, bus.hit_pulse, bus.miss_pulse, bus.game_over};
      n_compared++;
      if (act !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL hit/%s: got vis=%h score=%0d lives=%0d hit/miss/over=%b%b%b, want vis=%h score=%0d lives=%0d hit/miss/over=%b%b%b",
                 tag, act[OBS_W-1 -: NH], act[SW+LW+2 -: SW], act[LW+2 -: LW], act[2], act[1], act[0],
                 exp[OBS_W-1 -: NH], exp[SW+LW+2 -: SW], exp[LW+2 -: LW], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_hit_miss();
    row_t rows[$];
    rows.push_back(mk("hit_and_miss",   0, 0, 5, 'h21, 0, 1, 3, 1, 1, 0));
    rows.push_back(mk("release",        0, 0, 5, 0,    0, 1, 3, 0, 0, 0));
    rows.push_back(mk("wave_end_clean", 0, 0, 0, 0,    0, 1, 3, 0, 0, 0));
    rows.push_back(mk("miss_to_zero",   0, 0, 0, 1,    0, 0, 3, 0, 1, 0));
    rows.push_back(mk("release2",       0, 0, 0, 0,    0, 0, 3, 0, 0, 0));
    rows.push_back(mk("miss_at_zero",   0, 0, 0, 2,    0, 0, 3, 0, 1, 0));
    rows.push_back(mk("release3",       0, 0, 0, 0,    0, 0, 3, 0, 0, 0));
    foreach (rows[i]) begin
      obs_t exp, act;
      string tag;
      applyStimulus(rows[i]);
      step();
      exp = sb.pop_front();
      tag = tag_q.pop_front();
      act = {bus.visible_moles, bus.score, bus.lives, bus.hit_pulse, bus.miss_pulse, bus.game_over};
      n_compared++;
      if (act !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL hitmiss/%s: got vis=%h score=%0d lives=%0d hit/miss/over=%b%b%b, want vis=%h score=%0d lives=%0d hit/miss/over=%b%b%b",
                 tag, act[OBS_W-1 -: NH], act[SW+LW+2 -: SW], act[LW+2 -: LW], act[2], act[1], act[0],
                 exp[OBS_W-1 -: NH], exp[SW+LW+2 -: SW], exp[LW+2 -: LW], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_escape();
    row_t rows[$];
    rows.push_back(mk("wave_up",        0, 0, 'h15, 0, 'h15, 0, 3, 0, 0, 0));
    rows.push_back(mk("wave_end_press", 0, 0, 0,    1, 0,    0, 2, 0, 1, 0));
    rows.push_back(mk("after",          0, 0, 0,    0, 0,    0, 2, 0, 0, 0));
    rows.push_back(mk("after2",         0, 0, 0,    0, 0,    0, 2, 0, 0, 0));
    foreach (rows[i]) begin
      obs_t exp, act;
      string tag;
      applyStimulus(rows[i]);
      step();
      exp = sb.pop_front();
      tag = tag_q.pop_front();
      act = {bus.visible_moles, bus.score, bus.lives, bus.hit_pulse, bus.miss_pulse, bus.game_over};
      n_compared++;
      if (act !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL escape/%s: got vis=%h score=%0d lives=%0d hit/miss/over=%b%b%b, want vis=%h score=%0d lives=%0d hit/miss/over=%b%b%b",
                 tag, act[OBS_W-1 -: NH], act[SW+LW+2 -: SW], act[LW+2 -: LW], act[2], act[1], act[0],
                 exp[OBS_W-1 -: NH], exp[SW+LW+2 -: SW], exp[LW+2 -: LW], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_game_over();
    row_t rows[$];
    rows.push_back(mk("w2_up",       0, 0, 3, 0, 3, 0, 2, 0, 0, 0));
    rows.push_back(mk("w2_end",      0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    rows.push_back(mk("w3_up",       0, 0, 3, 0, 3, 0, 1, 0, 0, 0));
    rows.push_back(mk("w3_hit0",     0, 0, 3, 1, 2, 1, 1, 1, 0, 0));
    rows.push_back(mk("w3_rel",      0, 0, 3, 0, 2, 1, 1, 0, 0, 0));
    rows.push_back(mk("w3_end",      0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    rows.push_back(mk("over_press",  0, 0, 5, 1, 0, 1, 0, 0, 0, 1));
    rows.push_back(mk("over_clear",  0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    rows.push_back(mk("restart",     0, 1, 0, 0, 0, 0, 3, 0, 0, 0));
    rows.push_back(mk("restart_low", 0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    foreach (rows[i]) begin
      obs_t exp, act;
      string tag;
      applyStimulus(rows[i]);
      step();
      exp = sb.pop_front();
      tag = tag_q.pop_front();
      act = {bus.visible_moles, bus.score, bus.lives, bus.hit_pulse, bus.miss_pulse, bus.game_over};
      n_compared++;
      if (act !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL gameover/%s: got vis=%h score=%0d lives=%0d hit/miss/over=%b%b%b, want vis=%h score=%0d lives=%0d hit/miss/over=%b%b%b",
                 tag, act[OBS_W-1 -: NH], act[SW+LW+2 -: SW], act[LW+2 -: LW], act[2], act[1], act[0],
                 exp[OBS_W-1 -: NH], exp[SW+LW+2 -: SW], exp[LW+2 -: LW], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  // Full-board waves (18 hits each) climb the score into saturation, then a
  // three-mole wave confirms the ceiling holds.
  task automatic test_saturation();
    row_t rows[$];
    int   ms = 0;
    for (int k = 0; k < 80 && ms < SMAX; k++) begin
      int nxt;
      nxt = (ms + 18 > SMAX) ? SMAX : ms + 18;
      rows.push_back(mk("sat_up",  0, 0, ALL, 0,   ALL, ms,  3, 0, 0, 0));
      rows.push_back(mk("sat_hit", 0, 0, ALL, ALL, 0,   nxt, 3, 1, 0, 0));
      rows.push_back(mk("sat_end", 0, 0, 0,   0,   0,   nxt, 3, 0, 0, 0));
      ms = nxt;
    end
    rows.push_back(mk("top_up",   0, 0, 7, 0, 7, SMAX, 3, 0, 0, 0));
    rows.push_back(mk("top_hit3", 0, 0, 7, 7, 0, SMAX, 3, 1, 0, 0));
    rows.push_back(mk("top_rel",  0, 0, 7, 0, 0, SMAX, 3, 0, 0, 0));
    foreach (rows[i]) begin
      obs_t exp, act;
      string tag;
      applyStimulus(rows[i]);
      step();
      exp = sb.pop_front();
      tag = tag_q.pop_front();
      act = {bus.visible_moles, bus.score, bus.lives, bus.hit_pulse, bus.miss_pulse, bus.game_over};
      n_compared++;
      if (act !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL sat/%s[%0d]: got vis=%h score=%0d lives=%0d hit/miss/over=%b%b%b, want vis=%h score=%0d lives=%0d hit/miss/over=%b%b%b",
                 tag, i, act[OBS_W-1 -: NH], act[SW+LW+2 -: SW], act[LW+2 -: LW], act[2], act[1], act[0],
                 exp[OBS_W-1 -: NH], exp[SW+LW+2 -: SW], exp[LW+2 -: LW], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    rows.push_back(mk("mid_reset",     1, 0, 7, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk("post_reset",    0, 0, 7, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk("restart_after", 0, 1, 0, 0, 0, 0, 3, 0, 0, 0));
    rows.push_back(mk("restart_low",   0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    foreach (rows[i]) begin
      obs_t exp, act;
      string tag;
      applyStimulus(rows[i]);
      step();
      exp = sb.pop_front();
      tag = tag_q.pop_front();
      act = {bus.visible_moles, bus.score, bus.lives, bus.hit_pulse, bus.miss_pulse, bus.game_over};
      n_compared++;
      if (act !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL midreset/%s: got vis=%h score=%0d lives=%0d hit/miss/over=%b%b%b, want vis=%h score=%0d lives=%0d hit/miss/over=%b%b%b",
                 tag, act[OBS_W-1 -: NH], act[SW+LW+2 -: SW], act[LW+2 -: LW], act[2], act[1], act[0],
                 exp[OBS_W-1 -: NH], exp[SW+LW+2 -: SW], exp[LW+2 -: LW], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start          = 1'b0;
    bus.mole_positions = '0;
    bus.buttons        = '0;
    reset              = 1'b1;
    test_reset();
    test_start();
    test_hit();
    test_hit_miss();
    test_escape();
    test_game_over();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
